// File: rtl/regfile_pkg.sv
// Shared widths and constants for the NPC general-purpose register file.
package regfile_pkg;
    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 32;
    localparam int RF_DEPTH  = 1 << RF_ADDR_W;
    localparam int ZERO_IDX  = 0;

    function automatic int rf_depth(input int addr_w);
        return 1 << addr_w;
    endfunction
endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: zero-register check, write bypass and busy override.
module rf_read_port
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_W,
    parameter int DATA_WIDTH = RF_DATA_W,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                  rst,
    input  logic                  wen,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    input  logic [DATA_WIDTH-1:0] rf_data,
    input  logic                  busy_bit,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rbusy
);
    logic is_zero;
    logic hit;

    assign is_zero = (ZERO_REG != 0) && (raddr == ADDR_WIDTH'(ZERO_IDX));
    // A write landing this cycle satisfies the reader, so it is neither stale nor busy.
    assign hit     = (BYPASS != 0) && wen && !rst && (waddr == raddr);

    always_comb begin
        rdata = rf_data;
        if (hit)
            rdata = wdata;
        if (is_zero)
            rdata = '0;
    end

    assign rbusy = busy_bit && !rst && !hit && !is_zero;
endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file with busy scoreboard, optional zero register and write bypass.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_W,
    parameter int DATA_WIDTH = RF_DATA_W,
    parameter int NR_READ    = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wen,
    input  logic [ADDR_WIDTH-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0]         wdata,
    input  logic [NR_READ*ADDR_WIDTH-1:0] raddr,
    output logic [NR_READ*DATA_WIDTH-1:0] rdata,
    output logic [NR_READ-1:0]            rbusy,
    input  logic                          set_busy,
    input  logic [ADDR_WIDTH-1:0]         set_addr,
    input  logic                          flush
);
    localparam int DEPTH = rf_depth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] rf [DEPTH];
    logic [DEPTH-1:0]      busy;
    logic                  wr_ok;
    logic                  set_ok;

    assign wr_ok  = wen && !((ZERO_REG != 0) && (waddr == ADDR_WIDTH'(ZERO_IDX)));
    assign set_ok = set_busy && !((ZERO_REG != 0) && (set_addr == ADDR_WIDTH'(ZERO_IDX)));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                rf[i] <= '0;
        end else if (wr_ok) begin
            rf[waddr] <= wdata;
        end
    end

    // Set is applied after clear so a new producer supersedes a same-cycle writeback.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            busy <= '0;
        end else begin
            if (wen)
                busy[waddr] <= 1'b0;
            if (set_ok)
                busy[set_addr] <= 1'b1;
        end
    end

    for (genvar k = 0; k < NR_READ; k++) begin : g_port
        logic [ADDR_WIDTH-1:0] ra;
        assign ra = raddr[k*ADDR_WIDTH +: ADDR_WIDTH];

        rf_read_port #(
            .ADDR_WIDTH(ADDR_WIDTH),
            .DATA_WIDTH(DATA_WIDTH),
            .ZERO_REG  (ZERO_REG),
            .BYPASS    (BYPASS)
        ) u_port (
            .rst     (rst),
            .wen     (wen),
            .waddr   (waddr),
            .wdata   (wdata),
            .raddr   (ra),
            .rf_data (rf[ra]),
            .busy_bit(busy[ra]),
            .rdata   (rdata[k*DATA_WIDTH +: DATA_WIDTH]),
            .rbusy   (rbusy[k])
        );
    end
endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: scripted vector table, hand sequences for the no-bypass variant, random vs model.
module tb_regfile_sb;
    logic         clk = 1'b0;
    logic         rst, wen, set_busy, flush;
    logic [4:0]   waddr, set_addr;
    logic [31:0]  wdata;
    logic [19:0]  raddr;
    logic [127:0] rdata;
    logic [3:0]   rbusy;
    logic [4:0]   raddr2;
    logic [31:0]  rdata2;
    logic         rbusy2;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [32];
    logic        bsy [32];

    always #5 clk = ~clk;

    regfile_sb #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NR_READ(4), .ZERO_REG(1), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
        .set_busy(set_busy), .set_addr(set_addr), .flush(flush)
    );

    regfile_sb #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NR_READ(1), .ZERO_REG(0), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
        .raddr(raddr2), .rdata(rdata2), .rbusy(rbusy2),
        .set_busy(set_busy), .set_addr(set_addr), .flush(flush)
    );

    typedef struct {
        logic         rst, wen;
        logic [4:0]   waddr;
        logic [31:0]  wdata;
        logic         sb;
        logic [4:0]   saddr;
        logic         fl;
        logic [19:0]  ra;
        logic [127:0] ed;
        logic [3:0]   eb;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic w, input int wa, input logic [31:0] wd,
                                input logic s, input int sa, input logic f,
                                input int r0, input int r1, input int r2, input int r3,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic [31:0] d2, input logic [31:0] d3,
                                input logic [3:0] eb);
        vec_t v;
        v.rst = r; v.wen = w; v.waddr = 5'(wa); v.wdata = wd;
        v.sb = s; v.saddr = 5'(sa); v.fl = f;
        v.ra = {5'(r3), 5'(r2), 5'(r1), 5'(r0)};
        v.ed = {d3, d2, d1, d0};
        v.eb = eb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst; wen = v.wen; waddr = v.waddr; wdata = v.wdata;
        set_busy = v.sb; set_addr = v.saddr; flush = v.fl; raddr = v.ra;
    endtask

    // Reference read: zero register, then a write arriving now, then the stored array.
    function automatic logic [31:0] mread(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (wen && !rst && waddr == a) return wdata;
        return mem[a];
    endfunction

    function automatic logic mbusy(input logic [4:0] a);
        if (rst || a == 0 || (wen && waddr == a)) return 1'b0;
        return bsy[a];
    endfunction

    task automatic mcheck(input string tag);
        logic [127:0] ed;
        logic [3:0]   eb;
        for (int k = 0; k < 4; k++) begin
            ed[k*32 +: 32] = mread(raddr[k*5 +: 5]);
            eb[k]          = mbusy(raddr[k*5 +: 5]);
        end
        chk({tag, "_rdata"}, rdata, ed);
        chk({tag, "_rbusy"}, {124'b0, rbusy}, {124'b0, eb});
    endtask

    task automatic mupd();
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                mem[i] = 32'h0;
                bsy[i] = 1'b0;
            end
        end else begin
            if (wen && waddr != 0) mem[waddr] = wdata;
            if (flush) begin
                for (int i = 0; i < 32; i++) bsy[i] = 1'b0;
            end else begin
                if (wen) bsy[waddr] = 1'b0;
                if (set_busy && set_addr != 0) bsy[set_addr] = 1'b1;
            end
        end
    endtask

    task automatic end_cycle();
        @(posedge clk);
        mupd();
        #1;
    endtask

    task automatic hand(input vec_t v, input logic [4:0] a2, input string tag,
                        input logic [31:0] exp_d2, input logic exp_b2);
        drive(v);
        raddr2 = a2;
        @(negedge clk);
        mcheck(tag);
        chk({tag, "_nb_rdata"}, {96'b0, rdata2}, {96'b0, exp_d2});
        chk({tag, "_nb_rbusy"}, {127'b0, rbusy2}, {127'b0, exp_b2});
        end_cycle();
    endtask

    localparam logic [31:0] D = 32'hDEADBEEF;

    initial begin
        vec_t v;
        raddr2 = 5'd0;
        drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0));
        end_cycle();
        end_cycle();

        tbl.push_back(mk(0, 0, 0, 0,             0, 0, 0,  5, 0, 3, 7,  0, 0, 0, 0,  4'b0000));
        tbl.push_back(mk(0, 1, 5, 32'h11111111,  0, 0, 0,  5, 5, 0, 1,  32'h11111111, 32'h11111111, 0, 0, 4'b0000));
        tbl.push_back(mk(1, 1, 5, 32'h22,        1, 6, 0,  5, 6, 5, 0,  32'h11111111, 0, 32'h11111111, 0, 4'b0000));
        tbl.push_back(mk(0, 0, 0, 0,             0, 0, 0,  5, 6, 0, 0,  0, 0, 0, 0,  4'b0000));
        tbl.push_back(mk(0, 1, 3, D,             0, 0, 0,  3, 3, 1, 2,  D, D, 0, 0,  4'b0000));
        tbl.push_back(mk(0, 0, 0, 0,             0, 0, 0,  3, 4, 3, 0,  D, 0, D, 0,  4'b0000));
        tbl.push_back(mk(0, 1, 0, 32'h1234,      1, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0,  4'b0000));
        tbl.push_back(mk(0, 0, 0, 0,             0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0,  4'b0000));
        tbl.push_back(mk(0, 0, 0, 0,             1, 7, 0,  7, 7, 3, 0,  0, 0, D, 0,  4'b0000));
        tbl.push_back(mk(0, 0, 0, 0,             0, 0, 0,  7, 0, 7, 3,  0, 0, 0, D,  4'b0101));
        tbl.push_back(mk(0, 0, 0, 0,             0, 0, 0,  7, 7, 7, 7,  0, 0, 0, 0,  4'b1111));
        tbl.push_back(mk(0, 1, 7, 32'h55,        0, 0, 0,  7, 7, 0, 3,  32'h55, 32'h55, 0, D, 4'b0000));
        tbl.push_back(mk(0, 0, 0, 0,             0, 0, 0,  7, 0, 0, 0,  32'h55, 0, 0, 0, 4'b0000));
        tbl.push_back(mk(0, 0, 0, 0,             1, 9, 0,  9, 9, 7, 0,  0, 0, 32'h55, 0, 4'b0000));
        tbl.push_back(mk(0, 1, 9, 32'hA,         1, 9, 0,  9, 9, 8, 0,  32'hA, 32'hA, 0, 0, 4'b0000));
        tbl.push_back(mk(0, 0, 0, 0,             0, 0, 0,  9, 3, 9, 0,  32'hA, D, 32'hA, 0, 4'b0101));
        tbl.push_back(mk(0, 0, 0, 0,             1, 2, 0,  2, 9, 0, 0,  0, 32'hA, 0, 0, 4'b0010));
        tbl.push_back(mk(0, 0, 0, 0,             1, 4, 0,  2, 4, 0, 0,  0, 0, 0, 0,  4'b0001));
        tbl.push_back(mk(0, 0, 0, 0,             1, 6, 1,  2, 4, 6, 9,  0, 0, 0, 32'hA, 4'b1011));
        tbl.push_back(mk(0, 0, 0, 0,             0, 0, 0,  2, 4, 6, 9,  0, 0, 0, 32'hA, 4'b0000));
        tbl.push_back(mk(0, 0, 0, 0,             0, 0, 0,  3, 3, 3, 3,  D, D, D, D,  4'b0000));
        tbl.push_back(mk(0, 1, 3, 32'h77,        0, 0, 0,  3, 3, 3, 3,  32'h77, 32'h77, 32'h77, 32'h77, 4'b0000));

        foreach (tbl[i]) begin
            drive(tbl[i]);
            @(negedge clk);
            chk($sformatf("tbl%0d_rdata", i), rdata, tbl[i].ed);
            chk($sformatf("tbl%0d_rbusy", i), {124'b0, rbusy}, {124'b0, tbl[i].eb});
            end_cycle();
        end

        // Without bypass a just-written index shows the old value and stays busy for that cycle.
        hand(mk(0, 1, 12, D,     0, 0, 0,  12, 12, 0, 3,  0, 0, 0, 0, 4'b0), 5'd12, "nb_wr_same", 32'h0, 1'b0);
        hand(mk(0, 0, 0, 0,      0, 0, 0,  12, 3, 0, 0,   0, 0, 0, 0, 4'b0), 5'd12, "nb_wr_next", D, 1'b0);
        hand(mk(0, 0, 0, 0,      1, 13, 0, 13, 0, 0, 0,   0, 0, 0, 0, 4'b0), 5'd13, "nb_set",     32'h0, 1'b0);
        hand(mk(0, 1, 13, 32'h5, 0, 0, 0,  13, 13, 0, 0,  0, 0, 0, 0, 4'b0), 5'd13, "nb_clr_same", 32'h0, 1'b1);
        hand(mk(0, 0, 0, 0,      0, 0, 0,  13, 0, 0, 0,   0, 0, 0, 0, 4'b0), 5'd13, "nb_clr_next", 32'h5, 1'b0);
        hand(mk(0, 0, 0, 0,      0, 0, 0,  0, 0, 0, 0,    0, 0, 0, 0, 4'b0), 5'd0,  "nb_reg0",    32'h1234, 1'b0);

        for (int n = 0; n < 400; n++) begin
            v.rst   = ($urandom_range(0, 39) == 0);
            v.wen   = $urandom_range(0, 1) == 1;
            v.waddr = 5'($urandom_range(0, 15));
            v.wdata = $urandom;
            v.sb    = $urandom_range(0, 2) == 0;
            v.saddr = 5'($urandom_range(0, 15));
            v.fl    = ($urandom_range(0, 15) == 0);
            for (int k = 0; k < 4; k++)
                v.ra[k*5 +: 5] = 5'($urandom_range(0, 15));
            drive(v);
            raddr2 = 5'($urandom_range(0, 31));
            @(negedge clk);
            mcheck($sformatf("rnd%0d", n));
            end_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
